ksk_loader: RTL and testbench

//  Upstream feeder for the KSK URAM buffer. Accepts key-switching-key coefficients one per beat
//  on a valid/ready stream, packs 8 coefficients into one wide word and drives the buffer write

---
 rtl/ksk_loader.sv | 134 +++++++++++++
 tb/tb_ksk_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksk_loader.sv
// rtl/ksk_loader.sv - packs streamed KSK coefficients 8 per word and writes one stage into the URAM buffer
module ksk_loader #(
  parameter int DATA_WIDTH = 39,
  parameter int NUM_URAM   = 12,
  parameter int DEPTH      = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [3:0]              i_stage,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  output logic                    o_ksk_wr_en,
  output logic [3:0]              o_ksk_wr_stage,
  output logic [3:0]              o_ksk_wr_index,
  output logic [8:0]              o_ksk_wr_addr,
  output logic [8*DATA_WIDTH-1:0] o_ksk_wr_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [8:0] ADDR_LAST = 9'(DEPTH - 1);
  localparam logic [3:0] IDX_LAST  = 4'(NUM_URAM - 1);

  logic [1:0]              r_state;
  logic [3:0]              r_stage;
  logic [2:0]              r_lane;
  logic [8:0]              r_addr;
  logic [3:0]              r_index;
  logic [8*DATA_WIDTH-1:0] r_pack;
  logic                    r_done;
  logic                    r_err;
  logic                    r_wr_en;
  logic [3:0]              r_wr_stage;
  logic [3:0]              r_wr_index;
  logic [8:0]              r_wr_addr;
  logic [8*DATA_WIDTH-1:0] r_wr_data;

  logic w_beat;
  logic w_final;

  assign s_ready = (r_state == S_LOAD);
  assign o_busy  = (r_state == S_LOAD) || (r_state == S_DONE);
  assign w_beat  = s_valid && s_ready;
  // The stage's last coefficient is lane 7 of the word at the final bank/address.
  assign w_final = (r_lane == 3'd7) && (r_addr == ADDR_LAST) && (r_index == IDX_LAST);

  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_ksk_wr_en    = r_wr_en;
  assign o_ksk_wr_stage = r_wr_stage;
  assign o_ksk_wr_index = r_wr_index;
  assign o_ksk_wr_addr  = r_wr_addr;
  assign o_ksk_wr_data  = r_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_stage    <= '0;
      r_lane     <= '0;
      r_addr     <= '0;
      r_index    <= '0;
      r_pack     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_stage <= '0;
      r_wr_index <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start landing on the done pulse belongs to the finished load and is dropped.
          if (i_start && !r_done) begin
            r_state <= S_LOAD;
            r_stage <= i_stage;
            r_err   <= 1'b0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_index <= '0;
            r_pack  <= '0;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            if (s_last && !w_final) begin
              // Early end of stage: discard this beat and the partial word, then finish.
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              for (int k = 0; k < 8; k++) begin
                if (r_lane == 3'(k)) r_pack[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
              end
              r_lane <= r_lane + 3'd1;
              if (r_lane == 3'd7) begin
                r_wr_en    <= 1'b1;
                r_wr_stage <= r_stage;
                r_wr_index <= r_index;
                r_wr_addr  <= r_addr;
                r_wr_data  <= {s_data, r_pack[7*DATA_WIDTH-1:0]};
                if (r_addr == ADDR_LAST) begin
                  r_addr  <= '0;
                  r_index <= r_index + 4'd1;
                end else begin
                  r_addr <= r_addr + 9'd1;
                end
              end
              if (w_final) begin
                r_state <= S_DONE;
                if (!s_last) r_err <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksk_loader.sv
// tb/tb_ksk_loader.sv - directed self-checking bench for ksk_loader (2 banks x 4 words per stage)
module tb_ksk_loader;
  localparam int DW = 39;
  localparam int NU = 2;
  localparam int DP = 4;
  localparam int NB = 8 * NU * DP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [3:0]    i_stage = 4'd0;
  logic          o_busy, o_done, o_err;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          o_ksk_wr_en;
  logic [3:0]    o_ksk_wr_stage, o_ksk_wr_index;
  logic [8:0]    o_ksk_wr_addr;
  logic [8*DW-1:0] o_ksk_wr_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int double_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic prev_wr = 1'b0;
  logic [3:0]      q_stage[$];
  logic [3:0]      q_idx[$];
  logic [8:0]      q_addr[$];
  logic [8*DW-1:0] q_data[$];

  ksk_loader #(.DATA_WIDTH(DW), .NUM_URAM(NU), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stage(i_stage),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .o_ksk_wr_en(o_ksk_wr_en), .o_ksk_wr_stage(o_ksk_wr_stage), .o_ksk_wr_index(o_ksk_wr_index),
    .o_ksk_wr_addr(o_ksk_wr_addr), .o_ksk_wr_data(o_ksk_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_ksk_wr_en) begin
      q_stage.push_back(o_ksk_wr_stage);
      q_idx.push_back(o_ksk_wr_index);
      q_addr.push_back(o_ksk_wr_addr);
      q_data.push_back(o_ksk_wr_data);
      last_wr_cyc = cyc;
      if (prev_wr) double_cnt++;
    end
    prev_wr = o_ksk_wr_en;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Word n of a stage carries coefficients 8n..8n+7 in lanes 0..7.
  function automatic logic [8*DW-1:0] exp_word(input int n);
    logic [8*DW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*DW +: DW] = DW'(8 * n + k);
    return w;
  endfunction

  function automatic bit write_ok(input int n, input logic [3:0] st);
    return q_idx[n] === 4'(n / DP) && q_addr[n] === 9'(n % DP) &&
           q_stage[n] === st && q_data[n] === exp_word(n);
  endfunction

  task automatic clear_log();
    q_stage.delete(); q_idx.delete(); q_addr.delete(); q_data.delete();
    double_cnt = 0;
  endtask

  task automatic do_start(input logic [3:0] st);
    i_stage = st;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic stream(input int n, input int last_at, input bit rnd, input bit glitch,
                        output int acc, output int busy_low);
    int b = 0;
    int guard = 0;
    busy_low = 0;
    while (b < n && guard < 2000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = DW'(b);
      s_last  = (b == last_at);
      i_start = glitch && (b % 5 == 2);
      if (glitch) i_stage = 4'd9;
      @(negedge clk);
      if (!o_busy) busy_low++;
      if (s_valid && s_ready) b++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    i_start = 1'b0;
    acc = b;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int g = 0;
    ok = 1'b0;
    while (g < 100 && !ok) begin
      @(negedge clk); #1;
      if (done_cnt >= target) ok = 1'b1;
      g++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({o_busy, o_done, o_err, s_ready, o_ksk_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/err/ready/wr_en=%b expected 00000",
               {o_busy, o_done, o_err, s_ready, o_ksk_wr_en});
    end
    checks++;
    if ({o_ksk_wr_stage, o_ksk_wr_index, o_ksk_wr_addr} !== 17'd0 || o_ksk_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_wr: stage=%0d idx=%0d addr=%0d data=%h expected all 0",
               o_ksk_wr_stage, o_ksk_wr_index, o_ksk_wr_addr, o_ksk_wr_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b busy=%b expected 0 0", s_ready, o_busy);
    end
  endtask

  task automatic test_full_load(input bit rnd);
    int acc, busy_low, d0;
    bit ok;
    clear_log();
    d0 = done_cnt;
    do_start(4'd5);
    stream(NB, NB - 1, rnd, 1'b0, acc, busy_low);
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok || acc != NB || q_idx.size() != 8) begin
      errors++;
      $display("FAIL full_load_rnd%0d: done=%0d beats=%0d writes=%0d expected 1 %0d 8",
               rnd, ok, acc, q_idx.size(), NB);
    end
    for (int n = 0; n < q_idx.size() && n < 8; n++) begin
      checks++;
      if (!write_ok(n, 4'd5)) begin
        errors++;
        $display("FAIL full_load_rnd%0d_word%0d: idx=%0d addr=%0d stage=%0d data=%h expected idx=%0d addr=%0d stage=5 data=%h",
                 rnd, n, q_idx[n], q_addr[n], q_stage[n], q_data[n], n / DP, n % DP, exp_word(n));
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || o_err !== 1'b0 || busy_low != 0 || double_cnt != 0) begin
      errors++;
      $display("FAIL full_load_rnd%0d_status: done_pulses=%0d err=%b busy_low=%0d wide_wr=%0d expected 1 0 0 0",
               rnd, done_cnt - d0, o_err, busy_low, double_cnt);
    end
    checks++;
    if (done_cyc != last_wr_cyc + 1 || o_busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_load_rnd%0d_timing: done-lastwr=%0d busy=%b ready=%b expected 1 0 0",
               rnd, done_cyc - last_wr_cyc, o_busy, s_ready);
    end
  endtask

  task automatic test_early_last();
    int acc, busy_low, d0;
    bit ok;
    clear_log();
    d0 = done_cnt;
    do_start(4'd5);
    stream(21, 20, 1'b0, 1'b0, acc, busy_low);
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok || q_idx.size() != 2 || o_err !== 1'b1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL early_last: done=%0d writes=%0d err=%b pulses=%0d expected 1 2 1 1",
               ok, q_idx.size(), o_err, done_cnt - d0);
    end
    for (int n = 0; n < q_idx.size() && n < 2; n++) begin
      checks++;
      if (!write_ok(n, 4'd5)) begin
        errors++;
        $display("FAIL early_last_word%0d: idx=%0d addr=%0d data=%h expected idx=%0d addr=%0d data=%h",
                 n, q_idx[n], q_addr[n], q_data[n], n / DP, n % DP, exp_word(n));
      end
    end
  endtask

  task automatic test_missing_last();
    int acc, busy_low, d0;
    bit ok;
    clear_log();
    d0 = done_cnt;
    do_start(4'd5);
    stream(NB, -1, 1'b0, 1'b0, acc, busy_low);
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok || q_idx.size() != 8 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL missing_last: done=%0d writes=%0d err=%b expected 1 8 1", ok, q_idx.size(), o_err);
    end
    checks++;
    if (q_idx.size() == 8 && !write_ok(7, 4'd5)) begin
      errors++;
      $display("FAIL missing_last_final: idx=%0d addr=%0d data=%h expected idx=1 addr=3 data=%h",
               q_idx[7], q_addr[7], q_data[7], exp_word(7));
    end
    do_start(4'd5);
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears_err: err=%b busy=%b expected 0 1", o_err, o_busy);
    end
    @(posedge clk); #1;
    clear_log();
    stream(NB, NB - 1, 1'b0, 1'b0, acc, busy_low);
    wait_done(d0 + 2, ok);
    checks++;
    if (!ok || q_idx.size() != 8 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_load: done=%0d writes=%0d err=%b expected 1 8 0", ok, q_idx.size(), o_err);
    end
  endtask

  task automatic test_start_ignored();
    int acc, busy_low, g;
    clear_log();
    do_start(4'd5);
    stream(NB, NB - 1, 1'b0, 1'b1, acc, busy_low);
    g = 0;
    while (o_done !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    i_stage = 4'd9;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (g >= 100 || o_busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done: wait=%0d busy=%b ready=%b expected <100 0 0", g, o_busy, s_ready);
    end
    checks++;
    if (q_idx.size() != 8) begin
      errors++;
      $display("FAIL start_ignored_count: writes=%0d expected 8", q_idx.size());
    end
    for (int n = 0; n < q_idx.size() && n < 8; n++) begin
      checks++;
      if (!write_ok(n, 4'd5)) begin
        errors++;
        $display("FAIL start_ignored_word%0d: stage=%0d idx=%0d addr=%0d expected stage=5 idx=%0d addr=%0d",
                 n, q_stage[n], q_idx[n], q_addr[n], n / DP, n % DP);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midload();
    int acc, busy_low, d0;
    bit ok;
    clear_log();
    do_start(4'd5);
    stream(31, -1, 1'b0, 1'b0, acc, busy_low);
    checks++;
    if (q_idx.size() != 3) begin
      errors++;
      $display("FAIL pre_reset_writes: writes=%0d expected 3", q_idx.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_err, s_ready, o_ksk_wr_en} !== 5'b0 || o_ksk_wr_data !== '0 ||
        {o_ksk_wr_stage, o_ksk_wr_index, o_ksk_wr_addr} !== 17'd0) begin
      errors++;
      $display("FAIL reset_midload: ctrl=%b stage=%0d idx=%0d addr=%0d data=%h expected all 0",
               {o_busy, o_done, o_err, s_ready, o_ksk_wr_en}, o_ksk_wr_stage, o_ksk_wr_index,
               o_ksk_wr_addr, o_ksk_wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    d0 = done_cnt;
    do_start(4'd5);
    stream(NB, NB - 1, 1'b0, 1'b0, acc, busy_low);
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok || q_idx.size() != 8 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reload_after_reset: done=%0d writes=%0d err=%b expected 1 8 0", ok, q_idx.size(), o_err);
    end
    for (int n = 0; n < q_idx.size() && n < 8; n++) begin
      checks++;
      if (!write_ok(n, 4'd5)) begin
        errors++;
        $display("FAIL reload_word%0d: idx=%0d addr=%0d data=%h expected idx=%0d addr=%0d data=%h",
                 n, q_idx[n], q_addr[n], q_data[n], n / DP, n % DP, exp_word(n));
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_full_load(1'b0);
    test_full_load(1'b1);
    test_early_last();
    test_missing_last();
    test_start_ignored();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
